// File: rtl/ooo_read_reorder_master.sv
// ooo_read_reorder_master: host-side front end for a tagged, out-of-order slave.
// Host requests are forwarded combinationally. Reads take a reorder-buffer slot,
// and slave tids are mapped back to slots. Read data is returned to the host in
// issue order. Writes are posted and take no slot.
module ooo_read_reorder_master #(
  parameter int ROB_DEPTH = 4,
  parameter int TID_W     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             host_req,
  input  logic [31:0]      host_addr,
  input  logic             host_cmd,
  input  logic [31:0]      host_wdata,
  output logic             host_ack,
  output logic             host_resp,
  output logic [31:0]      host_rdata,
  output logic             master_req,
  output logic [31:0]      master_addr,
  output logic             master_cmd,
  output logic [31:0]      master_wdata,
  input  logic             master_ack,
  input  logic [TID_W-1:0] master_reqtid,
  input  logic             master_resp,
  input  logic [TID_W-1:0] master_resptid,
  input  logic [31:0]      master_rdata,
  output logic [2:0]       outstanding_o,
  output logic             err_o
);

  localparam int PTR_W   = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int NUM_TID = 2 ** TID_W;

  // Reorder buffer slots
  logic [ROB_DEPTH-1:0] slot_busy_q, slot_busy_d;
  logic [ROB_DEPTH-1:0] slot_done_q, slot_done_d;
  logic [31:0]          slot_data_q [ROB_DEPTH];
  logic [31:0]          slot_data_d [ROB_DEPTH];

  // Slave tid -> slot map
  logic [PTR_W-1:0]     tidmap_q [NUM_TID];
  logic [PTR_W-1:0]     tidmap_d [NUM_TID];
  logic [NUM_TID-1:0]   tidvalid_q, tidvalid_d;

  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [2:0]           count_q, count_d;
  logic                 host_resp_q, host_resp_d;
  logic [31:0]          host_rdata_q, host_rdata_d;
  logic                 err_q, err_d;

  logic                 rob_full;
  logic                 alloc;
  logic                 retire;
  logic                 resp_hit;
  logic                 resp_err;
  logic                 alloc_err;
  logic                 reqtid_freed;
  logic [PTR_W-1:0]     resp_slot;

  // Forward path and per-cycle event decode
  always_comb begin
    rob_full     = (count_q == 3'(ROB_DEPTH));
    master_addr  = host_addr;
    master_cmd   = host_cmd;
    master_wdata = host_wdata;
    master_req   = host_req & (host_cmd | ~rob_full);
    host_ack     = master_req & master_ack;
    alloc        = host_ack & ~host_cmd;
    retire       = slot_busy_q[head_q] & slot_done_q[head_q];
    resp_slot    = tidmap_q[master_resptid];
    resp_hit     = master_resp & tidvalid_q[master_resptid];
    resp_err     = master_resp & ~tidvalid_q[master_resptid];
    // A valid response on the same tid frees it, so reuse in that cycle is legal
    reqtid_freed = resp_hit & (master_resptid == master_reqtid);
    alloc_err    = alloc & tidvalid_q[master_reqtid] & ~reqtid_freed;
  end

  // Next-state for slots, tid map, pointers, count and host outputs
  always_comb begin
    slot_busy_d  = slot_busy_q;
    slot_done_d  = slot_done_q;
    slot_data_d  = slot_data_q;
    tidmap_d     = tidmap_q;
    tidvalid_d   = tidvalid_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q + {2'b00, alloc} - {2'b00, retire};
    host_resp_d  = retire;
    host_rdata_d = host_rdata_q;
    err_d        = err_q | resp_err | alloc_err;

    if (retire) begin
      host_rdata_d        = slot_data_q[head_q];
      slot_busy_d[head_q] = 1'b0;
      slot_done_d[head_q] = 1'b0;
      head_d = (head_q == PTR_W'(ROB_DEPTH - 1)) ? '0 : head_q + 1'b1;
    end

    // Responses use the mapping registered before this edge
    if (resp_hit) begin
      slot_data_d[resp_slot]     = master_rdata;
      slot_done_d[resp_slot]     = 1'b1;
      tidvalid_d[master_resptid] = 1'b0;
    end

    // Allocation comes last so a reused tid installs its new mapping
    if (alloc) begin
      slot_busy_d[tail_q]       = 1'b1;
      slot_done_d[tail_q]       = 1'b0;
      tidmap_d[master_reqtid]   = tail_q;
      tidvalid_d[master_reqtid] = 1'b1;
      tail_d = (tail_q == PTR_W'(ROB_DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_busy_q  <= '0;
      slot_done_q  <= '0;
      tidvalid_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      host_resp_q  <= 1'b0;
      host_rdata_q <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < ROB_DEPTH; i++) slot_data_q[i] <= '0;
      for (int i = 0; i < NUM_TID; i++)   tidmap_q[i]    <= '0;
    end else begin
      slot_busy_q  <= slot_busy_d;
      slot_done_q  <= slot_done_d;
      tidvalid_q   <= tidvalid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      host_resp_q  <= host_resp_d;
      host_rdata_q <= host_rdata_d;
      err_q        <= err_d;
      for (int i = 0; i < ROB_DEPTH; i++) slot_data_q[i] <= slot_data_d[i];
      for (int i = 0; i < NUM_TID; i++)   tidmap_q[i]    <= tidmap_d[i];
    end
  end

  // Registered outputs
  always_comb begin
    host_resp     = host_resp_q;
    host_rdata    = host_rdata_q;
    outstanding_o = count_q;
    err_o         = err_q;
  end

endmodule

// File: tb/tb_ooo_read_reorder_master.sv
// Scoreboard bench for ooo_read_reorder_master. Expected read data is queued
// at issue time in host order. A negedge monitor pops the queue and compares
// whenever host_resp is high.
module tb_ooo_read_reorder_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        host_req;
  logic [31:0] host_addr;
  logic        host_cmd;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic        host_resp;
  logic [31:0] host_rdata;
  logic        master_req;
  logic [31:0] master_addr;
  logic        master_cmd;
  logic [31:0] master_wdata;
  logic        master_ack;
  logic [1:0]  master_reqtid;
  logic        master_resp;
  logic [1:0]  master_resptid;
  logic [31:0] master_rdata;
  logic [2:0]  outstanding_o;
  logic        err_o;

  ooo_read_reorder_master #(.ROB_DEPTH(4), .TID_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_req(host_req), .host_addr(host_addr), .host_cmd(host_cmd),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_resp(host_resp),
    .host_rdata(host_rdata), .master_req(master_req), .master_addr(master_addr),
    .master_cmd(master_cmd), .master_wdata(master_wdata), .master_ack(master_ack),
    .master_reqtid(master_reqtid), .master_resp(master_resp),
    .master_resptid(master_resptid), .master_rdata(master_rdata),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          hr_count = 0;
  logic [31:0] sb_q [$];
  int          hr_cyc_q [$];

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every host_resp pulse must match the oldest queued expectation
  always @(negedge clk_i) begin
    if (!rst_i && host_resp) begin
      hr_count++;
      hr_cyc_q.push_back(cyc);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_host_resp: got data 0x%08h expected no response", host_rdata);
      end else begin
        chk("host_rdata", host_rdata, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    host_req = 1'b0; host_addr = '0; host_cmd = 1'b0; host_wdata = '0;
    master_ack = 1'b0; master_reqtid = '0;
    master_resp = 1'b0; master_resptid = '0; master_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    idle_inputs();
    step();
    step();
    rst_i = 1'b0;
    sb_q.delete();
    step();
  endtask

  task automatic do_read(input logic [1:0] tid, input logic [31:0] addr,
                         input logic [31:0] data, input bit push);
    host_req = 1'b1; host_cmd = 1'b0; host_addr = addr;
    master_ack = 1'b1; master_reqtid = tid;
    #1;
    chk("read_host_ack", {31'b0, host_ack}, 32'd1);
    if (push) sb_q.push_back(data);
    step();
    idle_inputs();
  endtask

  task automatic do_resp(input logic [1:0] tid, input logic [31:0] data, output int rc);
    master_resp = 1'b1; master_resptid = tid; master_rdata = data;
    rc = cyc;
    step();
    idle_inputs();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int rc;
  int t0;
  int hr_before;

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    #2;
    chk("reset_outstanding", {29'b0, outstanding_o}, 32'd0);
    chk("reset_err", {31'b0, err_o}, 32'd0);
    chk("reset_host_resp", {31'b0, host_resp}, 32'd0);
    chk("reset_host_rdata", host_rdata, 32'd0);
    apply_reset();

    // 1: single read, two-cycle latency from response to host_resp
    do_read(2'd0, 32'h10, 32'hA5A5A5A5, 1'b1);
    chk("t1_outstanding_1", {29'b0, outstanding_o}, 32'd1);
    hr_cyc_q.delete();
    do_resp(2'd0, 32'hA5A5A5A5, rc);
    wait_cycles(3);
    chk("t1_resp_count", hr_cyc_q.size(), 32'd1);
    if (hr_cyc_q.size() > 0) chk("t1_latency", hr_cyc_q[0] - rc, 32'd2);
    chk("t1_outstanding_0", {29'b0, outstanding_o}, 32'd0);

    // 2+3: fill the ROB, check full blocking and write posting, then reorder
    do_read(2'd0, 32'h0, 32'hD0D0_0000, 1'b1);
    do_read(2'd1, 32'h4, 32'hD1D1_1111, 1'b1);
    do_read(2'd2, 32'h8, 32'hD2D2_2222, 1'b1);
    do_read(2'd3, 32'hC, 32'hD3D3_3333, 1'b1);
    chk("t3_outstanding_full", {29'b0, outstanding_o}, 32'd4);
    host_req = 1'b1; host_cmd = 1'b0; host_addr = 32'h30; master_ack = 1'b1;
    #1;
    chk("t3_full_master_req", {31'b0, master_req}, 32'd0);
    chk("t3_full_host_ack", {31'b0, host_ack}, 32'd0);
    host_cmd = 1'b1; host_addr = 32'h20; host_wdata = 32'h12345678;
    #1;
    chk("t3_write_master_req", {31'b0, master_req}, 32'd1);
    chk("t3_write_host_ack", {31'b0, host_ack}, 32'd1);
    chk("t3_write_addr", master_addr, 32'h20);
    chk("t3_write_wdata", master_wdata, 32'h12345678);
    chk("t3_write_cmd", {31'b0, master_cmd}, 32'd1);
    master_ack = 1'b0;
    #1;
    chk("t3_write_noack", {31'b0, host_ack}, 32'd0);
    master_ack = 1'b1;
    step();
    idle_inputs();
    chk("t3_outstanding_after_write", {29'b0, outstanding_o}, 32'd4);
    hr_cyc_q.delete();
    do_resp(2'd3, 32'hD3D3_3333, rc);
    do_resp(2'd1, 32'hD1D1_1111, rc);
    do_resp(2'd0, 32'hD0D0_0000, t0);
    do_resp(2'd2, 32'hD2D2_2222, rc);
    wait_cycles(5);
    chk("t2_resp_count", hr_cyc_q.size(), 32'd4);
    if (hr_cyc_q.size() >= 2) begin
      chk("t2_d0_cycle", hr_cyc_q[0] - t0, 32'd2);
      chk("t2_d1_cycle", hr_cyc_q[1] - t0, 32'd3);
    end
    chk("t2_outstanding_0", {29'b0, outstanding_o}, 32'd0);
    chk("t2_err", {31'b0, err_o}, 32'd0);

    // 4: response and new read on the same tid in one cycle
    do_read(2'd0, 32'h40, 32'h11, 1'b1);
    master_resp = 1'b1; master_resptid = 2'd0; master_rdata = 32'h11;
    host_req = 1'b1; host_cmd = 1'b0; host_addr = 32'h44;
    master_ack = 1'b1; master_reqtid = 2'd0;
    #1;
    chk("t4_reuse_ack", {31'b0, host_ack}, 32'd1);
    sb_q.push_back(32'h22);
    step();
    idle_inputs();
    step();
    do_resp(2'd0, 32'h22, rc);
    wait_cycles(4);
    chk("t4_err", {31'b0, err_o}, 32'd0);
    chk("t4_outstanding_0", {29'b0, outstanding_o}, 32'd0);

    // 5: response on an unmapped tid
    apply_reset();
    hr_before = hr_count;
    do_resp(2'd2, 32'hDEADBEEF, rc);
    chk("t5_err_set", {31'b0, err_o}, 32'd1);
    wait_cycles(3);
    chk("t5_err_sticky", {31'b0, err_o}, 32'd1);
    chk("t5_no_host_resp", hr_count - hr_before, 32'd0);

    // 6: asynchronous reset mid-cycle with reads outstanding
    do_read(2'd0, 32'h50, 32'h0, 1'b0);
    do_read(2'd1, 32'h54, 32'h0, 1'b0);
    do_read(2'd2, 32'h58, 32'h0, 1'b0);
    chk("t6_outstanding_3", {29'b0, outstanding_o}, 32'd3);
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("t6_async_outstanding", {29'b0, outstanding_o}, 32'd0);
    chk("t6_async_host_resp", {31'b0, host_resp}, 32'd0);
    chk("t6_async_err", {31'b0, err_o}, 32'd0);
    #1 rst_i = 1'b0;
    step();
    do_read(2'd1, 32'h80, 32'hCAFEF00D, 1'b1);
    do_resp(2'd1, 32'hCAFEF00D, rc);
    wait_cycles(4);
    chk("t6_fresh_outstanding", {29'b0, outstanding_o}, 32'd0);
    chk("t6_fresh_err", {31'b0, err_o}, 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
